// File: rtl/player_motion.sv
// Player sprite motion: debounced buttons, frame-rate stepping, collision-checked commits
// and room transitions when the sprite crosses a screen edge.
module player_motion #(
    parameter int unsigned STEP_DIV   = 416667,
    parameter int unsigned STEP_PX    = 4,
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned MAP_W      = 3,
    parameter int unsigned MAP_H      = 3,
    parameter int unsigned X_MIN      = 97,
    parameter int unsigned X_MAX      = 720,
    parameter int unsigned Y_MIN      = 3,
    parameter int unsigned Y_MAX      = 466,
    parameter int unsigned X_START    = 408,
    parameter int unsigned Y_START    = 234,
    parameter int unsigned MX_START   = 1,
    parameter int unsigned MY_START   = 1
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision,
    output logic [9:0] x_pos_out,
    output logic [9:0] y_pos_out,
    output logic [2:0] mapa_pos_x_out,
    output logic [2:0] mapa_pos_y_out,
    output logic       busy
);
    localparam int unsigned TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StWait, StCheck} state_t;

    // Button vectors are ordered {up, down, left, right}.
    logic [3:0]    sync1_q, sync2_q, db_q;
    logic [DW-1:0] deb_cnt_q [4];
    logic [TW-1:0] tick_cnt_q;
    logic          tick;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [9:0]    x_q, x_d, y_q, y_d, sav_x_q, sav_x_d, sav_y_q, sav_y_d;
    logic [2:0]    mx_q, mx_d, my_q, my_d, sav_mx_q, sav_mx_d, sav_my_q, sav_my_d;
    logic          busy_q, busy_d;
    logic [9:0]    prop_x, prop_y;
    logic [2:0]    prop_mx, prop_my;
    logic [10:0]   x_w, y_w;

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {btn_up, btn_down, btn_left, btn_right};
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    db_q[i]      <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick = (tick_cnt_q == TW'(STEP_DIV - 1));

    always_ff @(posedge CLOCK_25) begin
        if (reset || tick) tick_cnt_q <= '0;
        else               tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // Edge checks are done 11 bits wide so x - STEP_PX cannot wrap below zero.
    always_comb begin
        prop_x  = x_q;
        prop_y  = y_q;
        prop_mx = mx_q;
        prop_my = my_q;
        x_w     = {1'b0, x_q};
        y_w     = {1'b0, y_q};
        if (db_q[3]) begin
            if (y_w < 11'(Y_MIN + STEP_PX)) begin
                if (my_q != 3'd0) begin
                    prop_my = my_q - 3'd1;
                    prop_y  = 10'(Y_MAX);
                end else begin
                    prop_y  = 10'(Y_MIN);
                end
            end else begin
                prop_y = y_q - 10'(STEP_PX);
            end
        end else if (db_q[2]) begin
            if (y_w + 11'(STEP_PX) > 11'(Y_MAX)) begin
                if (my_q < 3'(MAP_H - 1)) begin
                    prop_my = my_q + 3'd1;
                    prop_y  = 10'(Y_MIN);
                end else begin
                    prop_y  = 10'(Y_MAX);
                end
            end else begin
                prop_y = y_q + 10'(STEP_PX);
            end
        end else if (db_q[1]) begin
            if (x_w < 11'(X_MIN + STEP_PX)) begin
                if (mx_q != 3'd0) begin
                    prop_mx = mx_q - 3'd1;
                    prop_x  = 10'(X_MAX);
                end else begin
                    prop_x  = 10'(X_MIN);
                end
            end else begin
                prop_x = x_q - 10'(STEP_PX);
            end
        end else if (db_q[0]) begin
            if (x_w + 11'(STEP_PX) > 11'(X_MAX)) begin
                if (mx_q < 3'(MAP_W - 1)) begin
                    prop_mx = mx_q + 3'd1;
                    prop_x  = 10'(X_MIN);
                end else begin
                    prop_x  = 10'(X_MAX);
                end
            end else begin
                prop_x = x_q + 10'(STEP_PX);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        x_d      = x_q;
        y_d      = y_q;
        mx_d     = mx_q;
        my_d     = my_q;
        sav_x_d  = sav_x_q;
        sav_y_d  = sav_y_q;
        sav_mx_d = sav_mx_q;
        sav_my_d = sav_my_q;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (tick && (db_q != 4'd0)) begin
                    sav_x_d  = x_q;
                    sav_y_d  = y_q;
                    sav_mx_d = mx_q;
                    sav_my_d = my_q;
                    x_d      = prop_x;
                    y_d      = prop_y;
                    mx_d     = prop_mx;
                    my_d     = prop_my;
                    busy_d   = 1'b1;
                    settle_d = '0;
                    state_d  = StWait;
                end
            end
            // Gives the renderer time to look up the tile under the proposed position.
            StWait: begin
                if (settle_q == SW'(SETTLE - 1)) state_d  = StCheck;
                else                             settle_d = settle_q + 1'b1;
            end
            StCheck: begin
                if (collision) begin
                    x_d  = sav_x_q;
                    y_d  = sav_y_q;
                    mx_d = sav_mx_q;
                    my_d = sav_my_q;
                end
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q  <= StIdle;
            settle_q <= '0;
            x_q      <= 10'(X_START);
            y_q      <= 10'(Y_START);
            mx_q     <= 3'(MX_START);
            my_q     <= 3'(MY_START);
            sav_x_q  <= '0;
            sav_y_q  <= '0;
            sav_mx_q <= '0;
            sav_my_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            sav_x_q  <= sav_x_d;
            sav_y_q  <= sav_y_d;
            sav_mx_q <= sav_mx_d;
            sav_my_q <= sav_my_d;
            busy_q   <= busy_d;
        end
    end

    assign x_pos_out      = x_q;
    assign y_pos_out      = y_q;
    assign mapa_pos_x_out = mx_q;
    assign mapa_pos_y_out = my_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with shortened tick and debounce periods.
module tb_player_motion;
    localparam int unsigned SDIV = 32;
    localparam int unsigned DEB  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] x_pos_out, y_pos_out;
    logic [2:0] mapa_pos_x_out, mapa_pos_y_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    player_motion #(
        .STEP_DIV  (SDIV),
        .DEB_CYCLES(DEB)
    ) dut (
        .CLOCK_25      (clk),
        .reset         (reset),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .collision     (collision),
        .x_pos_out     (x_pos_out),
        .y_pos_out     (y_pos_out),
        .mapa_pos_x_out(mapa_pos_x_out),
        .mapa_pos_y_out(mapa_pos_y_out),
        .busy          (busy)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_rise();
        int n = 0;
        while (busy !== 1'b1 && n < 4 * SDIV) begin
            @(negedge clk);
            n++;
        end
        chk("step_start", busy, 1);
    endtask

    task automatic wait_fall(output int len);
        len = 0;
        while (busy === 1'b1 && len < 16) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic step(output int len);
        wait_rise();
        wait_fall(len);
    endtask

    initial begin
        int len;
        int busy_seen;

        // Reset state
        @(negedge clk);
        do_reset();
        chk("rst_x", x_pos_out, 408);
        chk("rst_y", y_pos_out, 234);
        chk("rst_mx", mapa_pos_x_out, 1);
        chk("rst_my", mapa_pos_y_out, 1);
        chk("rst_busy", busy, 0);

        // Hold right: three committed steps, busy high 3 cycles each
        btn_right = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(len);
            chk("right_x", x_pos_out, 408 + 4 * i);
            chk("right_busy_len", len, 3);
        end
        btn_right = 1'b0;
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        chk("right_release_x", x_pos_out, 420);
        chk("right_release_busy", busy_seen, 0);

        // Bounce shorter than the debounce window never moves the sprite
        do_reset();
        btn_up = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        btn_up = 1'b0;
        busy_seen = 0;
        repeat (5 * SDIV) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        chk("bounce_y", y_pos_out, 234);
        chk("bounce_busy", busy_seen, 0);

        // Collision during check reverts the step
        do_reset();
        collision = 1'b1;
        btn_left  = 1'b1;
        wait_rise();
        chk("coll_proposed_x", x_pos_out, 404);
        wait_fall(len);
        chk("coll_revert_x", x_pos_out, 408);
        chk("coll_revert_mx", mapa_pos_x_out, 1);
        btn_left  = 1'b0;
        collision = 1'b0;

        // Up has priority over right
        do_reset();
        btn_up    = 1'b1;
        btn_right = 1'b1;
        step(len);
        chk("prio_y1", y_pos_out, 230);
        chk("prio_x1", x_pos_out, 408);
        step(len);
        chk("prio_y2", y_pos_out, 226);
        chk("prio_x2", x_pos_out, 408);
        btn_up    = 1'b0;
        btn_right = 1'b0;

        // Walk left through the room edge at col 1, then clamp at col 0
        do_reset();
        btn_left = 1'b1;
        for (int i = 1; i <= 77; i++) begin
            step(len);
            chk("walk1_x", x_pos_out, 408 - 4 * i);
        end
        chk("edge_mx_before", mapa_pos_x_out, 1);
        step(len);
        chk("edge_wrap_x", x_pos_out, 720);
        chk("edge_wrap_mx", mapa_pos_x_out, 0);
        for (int i = 1; i <= 155; i++) begin
            step(len);
            chk("walk0_x", x_pos_out, 720 - 4 * i);
        end
        step(len);
        chk("clamp_x", x_pos_out, 97);
        chk("clamp_mx", mapa_pos_x_out, 0);
        step(len);
        chk("clamp2_x", x_pos_out, 97);
        chk("clamp2_mx", mapa_pos_x_out, 0);
        btn_left = 1'b0;

        // Reset while a room change is pending
        do_reset();
        btn_up = 1'b1;
        for (int i = 1; i <= 57; i++) step(len);
        chk("top_y", y_pos_out, 6);
        wait_rise();
        chk("pend_y", y_pos_out, 466);
        chk("pend_my", mapa_pos_y_out, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_x", x_pos_out, 408);
        chk("abort_y", y_pos_out, 234);
        chk("abort_mx", mapa_pos_x_out, 1);
        chk("abort_my", mapa_pos_y_out, 1);
        chk("abort_busy", busy, 0);
        btn_up = 1'b0;
        reset  = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
